stream_fifo_burst_arbiter: RTL

Round-robin, burst-granular arbiter that shares one StreamingFIFO input between NUM_IN AXI-Stream producers. It grants one producer at a time for exactly BURST beats, so streams interleave only at burst boundaries. It starts a new burst only while the FIFO's reported occupancy leaves room for a whole burst. It sits directly in front of a StreamingFIFO instance and consumes that FIFO's count output.

---
 rtl/stream_fifo_burst_arbiter_pkg.sv | 22 ++
 rtl/stream_fifo_burst_arbiter_rr_pick.sv | 30 +++
 rtl/stream_fifo_burst_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/stream_fifo_burst_arbiter_pkg.sv
// Shared types and helpers for the burst-granular round-robin FIFO arbiter.
package stream_fifo_burst_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_BURST   = 8;
  localparam int BURST_CNT_W = clog2(DEF_BURST + 1);

endpackage

// File: rtl/stream_fifo_burst_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after i_last, wrapping.
module rr_pick
  import stream_fifo_burst_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_any,
  output logic [IW-1:0] o_idx
);

  int w_j;

  // Scan farthest-first so the nearest requester after i_last wins.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    w_j   = 0;
    for (int k = N; k >= 1; k--) begin
      w_j = (int'(i_last) + k) % N;
      if (i_req[w_j]) begin
        o_any = 1'b1;
        o_idx = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/stream_fifo_burst_arbiter.sv
// Shares one StreamingFIFO input among NUM_IN producers, one BURST-beat grant
// at a time, starting a burst only while the FIFO count leaves room for it.
module stream_fifo_burst_arbiter
  import stream_fifo_burst_arbiter_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int WIDTH     = 72,
  parameter int BURST     = 8,
  parameter int CNT_W     = 5,
  parameter int START_MAX = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [NUM_IN*WIDTH-1:0]   in_V_TDATA,
  input  logic [NUM_IN-1:0]         in_V_TVALID,
  output logic [NUM_IN-1:0]         in_V_TREADY,
  output logic [WIDTH-1:0]          out_V_TDATA,
  output logic                      out_V_TVALID,
  input  logic                      out_V_TREADY,
  input  logic [CNT_W-1:0]          fifo_count,
  output logic [clog2(NUM_IN)-1:0]  grant_id,
  output logic                      busy,
  output logic [31:0]               burst_total
);

  localparam int GW  = clog2(NUM_IN);
  localparam int BCW = clog2(BURST + 1);
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_MAX);

  state_t          r_state;
  logic [GW-1:0]   r_last;
  logic [BCW-1:0]  r_beat;
  logic [31:0]     r_burst_total;

  logic            w_any;
  logic [GW-1:0]   w_pick;
  logic            w_room;
  logic            w_busy;
  logic            w_beat;

  assign w_busy = (r_state == XFER);
  assign w_room = (fifo_count <= START_LIM);

  rr_pick #(.N(NUM_IN), .IW(GW)) u_rr_pick (
    .i_req  (in_V_TVALID),
    .i_last (r_last),
    .o_any  (w_any),
    .o_idx  (w_pick)
  );

  // Handshake: a beat moves when out_V_TVALID and out_V_TREADY are both high;
  // the granted producer sees the FIFO's ready directly, all others see 0.
  always_comb begin
    out_V_TDATA  = '0;
    out_V_TVALID = 1'b0;
    in_V_TREADY  = '0;
    if (w_busy) begin
      out_V_TDATA         = in_V_TDATA[int'(r_last)*WIDTH +: WIDTH];
      out_V_TVALID        = in_V_TVALID[r_last];
      in_V_TREADY[r_last] = out_V_TREADY;
    end
  end

  assign w_beat = out_V_TVALID & out_V_TREADY;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state       <= IDLE;
      r_last        <= GW'(NUM_IN - 1);
      r_beat        <= '0;
      r_burst_total <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // A blocked space check leaves r_last alone so nobody loses their turn.
          if (w_any && w_room) begin
            r_state <= XFER;
            r_last  <= w_pick;
            r_beat  <= '0;
          end
        end
        XFER: begin
          if (w_beat) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == BCW'(BURST - 1)) begin
              r_state       <= IDLE;
              r_burst_total <= r_burst_total + 32'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_id    = r_last;
  assign busy        = w_busy;
  assign burst_total = r_burst_total;

endmodule
